// File: rtl/stage4_integration.sv
// Stage-4 integration of the 16-bit stack-machine CPU: multicycle control FSM,
// barrel shifter and the 12->16 zero/sign extenders.
module stage4_integration (
  input  logic        CLK,
  input  logic        CtrlRst,
  input  logic [15:0] IROut,
  input  logic        isZero,
  input  logic [15:0] ShifterIn,
  output logic [15:0] ShifterOut,
  output logic [15:0] ZeroExtOut,
  output logic [15:0] SignExtOut,
  output logic        PCSource,
  output logic        PCWrite,
  output logic        PCAdd,
  output logic        MSPop,
  output logic        MSPWrite,
  output logic        RSPop,
  output logic        RSPWrite,
  output logic        IRWrite,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        ResWrite,
  output logic        ResSource,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [2:0]  MemData,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic [2:0]  ALUop
);

  localparam logic [4:0] FETCH  = 5'd0;
  localparam logic [4:0] DECODE = 5'd1;
  localparam logic [4:0] ALU    = 5'd2;
  localparam logic [4:0] WBPOP  = 5'd3;
  localparam logic [4:0] SHIFT  = 5'd4;
  localparam logic [4:0] WBTOP  = 5'd5;
  localparam logic [4:0] PUSHI  = 5'd6;
  localparam logic [4:0] PUSHW  = 5'd7;
  localparam logic [4:0] JUMP   = 5'd8;
  localparam logic [4:0] BRZ    = 5'd9;
  localparam logic [4:0] CALL   = 5'd10;
  localparam logic [4:0] CALLW  = 5'd11;
  localparam logic [4:0] RET    = 5'd12;
  localparam logic [4:0] RETW   = 5'd13;

  logic [4:0] state_q;
  logic [4:0] state_d;
  logic [3:0] opcode;
  logic       amt_big;
  logic [3:0] amt;

  assign opcode  = IROut[15:12];
  assign amt     = IROut[3:0];
  assign amt_big = |IROut[11:4];

  // Shifter and extenders: amounts of 16 or more saturate
  always_comb begin
    ShifterOut = ShifterIn;
    case (opcode)
      4'b1000: ShifterOut = amt_big ? 16'h0000 : (ShifterIn << amt);
      4'b1001: ShifterOut = amt_big ? 16'h0000 : (ShifterIn >> amt);
      4'b1010: ShifterOut = amt_big ? {16{ShifterIn[15]}}
                                    : 16'($signed(ShifterIn) >>> amt);
      default: ShifterOut = ShifterIn;
    endcase
    ZeroExtOut = {4'h0, IROut[11:0]};
    SignExtOut = {{4{IROut[11]}}, IROut[11:0]};
  end

  always_ff @(posedge CLK) begin
    if (CtrlRst) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Next state; illegal codes fall back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: state_d = ALU;
          4'b1000, 4'b1001, 4'b1010:                   state_d = SHIFT;
          4'b1011: state_d = PUSHI;
          4'b1100: state_d = JUMP;
          4'b1101: state_d = BRZ;
          4'b1110: state_d = CALL;
          4'b1111: state_d = RET;
          default: state_d = FETCH;
        endcase
      end
      ALU:    state_d = WBPOP;
      SHIFT:  state_d = WBTOP;
      PUSHI:  state_d = PUSHW;
      CALL:   state_d = CALLW;
      RET:    state_d = RETW;
      default: state_d = FETCH;
    endcase
  end

  // Moore control decode, held at zero while reset is asserted
  always_comb begin
    PCSource  = 1'b0;
    PCWrite   = 1'b0;
    PCAdd     = 1'b0;
    MSPop     = 1'b0;
    MSPWrite  = 1'b0;
    RSPop     = 1'b0;
    RSPWrite  = 1'b0;
    IRWrite   = 1'b0;
    ValAWrite = 1'b0;
    ValBWrite = 1'b0;
    ResWrite  = 1'b0;
    ResSource = 1'b0;
    MemDst1   = 2'b00;
    MemDst2   = 2'b00;
    MemData   = 3'b000;
    MemWrite1 = 1'b0;
    MemWrite2 = 1'b0;
    MemRead1  = 1'b0;
    MemRead2  = 1'b0;
    ALUop     = 3'b000;
    if (!CtrlRst) begin
      case (state_q)
        FETCH: begin
          MemRead1 = 1'b1;
          IRWrite  = 1'b1;
          PCWrite  = 1'b1;
        end
        DECODE: begin
          MemDst1   = 2'b01;
          MemRead1  = 1'b1;
          ValAWrite = 1'b1;
          MemDst2   = 2'b10;
          MemRead2  = 1'b1;
          ValBWrite = 1'b1;
        end
        ALU: begin
          ALUop    = opcode[2:0];
          ResWrite = 1'b1;
        end
        WBPOP: begin
          MemDst1   = 2'b10;
          MemWrite1 = 1'b1;
          MSPop     = 1'b1;
          MSPWrite  = 1'b1;
        end
        SHIFT: begin
          ResSource = 1'b1;
          ResWrite  = 1'b1;
        end
        WBTOP: begin
          MemDst1   = 2'b01;
          MemWrite1 = 1'b1;
        end
        PUSHI: MSPWrite = 1'b1;
        PUSHW: begin
          MemDst1   = 2'b01;
          MemData   = 3'b010;
          MemWrite1 = 1'b1;
        end
        JUMP: begin
          PCSource = 1'b1;
          PCWrite  = 1'b1;
        end
        BRZ: begin
          ALUop    = 3'b001;
          PCAdd    = isZero;
          PCWrite  = isZero;
          MSPop    = 1'b1;
          MSPWrite = 1'b1;
        end
        CALL: RSPWrite = 1'b1;
        CALLW: begin
          MemDst2   = 2'b11;
          MemData   = 3'b011;
          MemWrite2 = 1'b1;
          PCSource  = 1'b1;
          PCWrite   = 1'b1;
        end
        RET: begin
          MemDst2  = 2'b11;
          MemRead2 = 1'b1;
          RSPop    = 1'b1;
          RSPWrite = 1'b1;
        end
        RETW: begin
          PCSource = 1'b1;
          PCAdd    = 1'b1;
          PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage4_integration.sv
// Bench for stage4_integration: datapath vector table, random datapath sweep,
// random instruction streams against a per-instruction cycle plan, reset/BRZ sequences.
module tb_stage4_integration;

  logic        CLK = 1'b0;
  logic        CtrlRst;
  logic [15:0] IROut;
  logic        isZero;
  logic [15:0] ShifterIn;
  logic [15:0] ShifterOut, ZeroExtOut, SignExtOut;
  logic        PCSource, PCWrite, PCAdd, MSPop, MSPWrite, RSPop, RSPWrite;
  logic        IRWrite, ValAWrite, ValBWrite, ResWrite, ResSource;
  logic [1:0]  MemDst1, MemDst2;
  logic [2:0]  MemData;
  logic        MemWrite1, MemWrite2, MemRead1, MemRead2;
  logic [2:0]  ALUop;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pc_source, pc_write, pc_add, ms_pop, ms_pwrite, rs_pop, rs_pwrite;
    logic       ir_write, vala_write, valb_write, res_write, res_source;
    logic [1:0] mem_dst1, mem_dst2;
    logic [2:0] mem_data;
    logic       mem_write1, mem_write2, mem_read1, mem_read2;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] sin;
    logic [15:0] exp_shift;
    logic [15:0] exp_zx;
    logic [15:0] exp_sx;
  } dp_vec_t;

  ctrl_t act;
  ctrl_t exp_q[$];

  assign act = {PCSource, PCWrite, PCAdd, MSPop, MSPWrite, RSPop, RSPWrite,
                IRWrite, ValAWrite, ValBWrite, ResWrite, ResSource,
                MemDst1, MemDst2, MemData, MemWrite1, MemWrite2, MemRead1, MemRead2, ALUop};

  stage4_integration dut (
    .CLK(CLK), .CtrlRst(CtrlRst), .IROut(IROut), .isZero(isZero), .ShifterIn(ShifterIn),
    .ShifterOut(ShifterOut), .ZeroExtOut(ZeroExtOut), .SignExtOut(SignExtOut),
    .PCSource(PCSource), .PCWrite(PCWrite), .PCAdd(PCAdd), .MSPop(MSPop), .MSPWrite(MSPWrite),
    .RSPop(RSPop), .RSPWrite(RSPWrite), .IRWrite(IRWrite), .ValAWrite(ValAWrite),
    .ValBWrite(ValBWrite), .ResWrite(ResWrite), .ResSource(ResSource),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
    .MemWrite1(MemWrite1), .MemWrite2(MemWrite2), .MemRead1(MemRead1), .MemRead2(MemRead2),
    .ALUop(ALUop)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference shifter using 32-bit arithmetic so large amounts saturate naturally
  function automatic logic [15:0] ref_shift(input logic [15:0] ir, input logic [15:0] sin);
    int unsigned       amt;
    logic [31:0]        w;
    logic signed [31:0] s;
    amt = 32'(ir[11:0]);
    w   = {16'h0000, sin};
    s   = signed'({{16{sin[15]}}, sin});
    case (ir[15:12])
      4'b1000: w = w << amt;
      4'b1001: w = w >> amt;
      4'b1010: w = 32'(s >>> amt);
      default: ;
    endcase
    return w[15:0];
  endfunction

  function automatic logic [15:0] ref_sext(input logic [15:0] ir);
    return ir[11] ? (16'hF000 | {4'h0, ir[11:0]}) : {4'h0, ir[11:0]};
  endfunction

  task automatic check_dp(input string tag);
    check({tag, " shift"}, 32'(ShifterOut), 32'(ref_shift(IROut, ShifterIn)));
    check({tag, " zext"}, 32'(ZeroExtOut), 32'({4'h0, IROut[11:0]}));
    check({tag, " sext"}, 32'(SignExtOut), 32'(ref_sext(IROut)));
  endtask

  // Expected control word for each cycle of one instruction, FETCH first
  task automatic plan(input logic [3:0] op, input logic iz);
    ctrl_t e;
    e = '0; e.mem_read1 = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    exp_q.push_back(e);
    e = '0; e.mem_dst1 = 2'b01; e.mem_read1 = 1'b1; e.vala_write = 1'b1;
    e.mem_dst2 = 2'b10; e.mem_read2 = 1'b1; e.valb_write = 1'b1;
    exp_q.push_back(e);
    if (op <= 4'd4) begin
      e = '0; e.alu_op = op[2:0]; e.res_write = 1'b1; exp_q.push_back(e);
      e = '0; e.mem_dst1 = 2'b10; e.mem_write1 = 1'b1; e.ms_pop = 1'b1; e.ms_pwrite = 1'b1;
      exp_q.push_back(e);
    end else if (op >= 4'd8 && op <= 4'd10) begin
      e = '0; e.res_source = 1'b1; e.res_write = 1'b1; exp_q.push_back(e);
      e = '0; e.mem_dst1 = 2'b01; e.mem_write1 = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd11) begin
      e = '0; e.ms_pwrite = 1'b1; exp_q.push_back(e);
      e = '0; e.mem_dst1 = 2'b01; e.mem_data = 3'b010; e.mem_write1 = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd12) begin
      e = '0; e.pc_source = 1'b1; e.pc_write = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd13) begin
      e = '0; e.alu_op = 3'b001; e.pc_add = iz; e.pc_write = iz; e.ms_pop = 1'b1;
      e.ms_pwrite = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd14) begin
      e = '0; e.rs_pwrite = 1'b1; exp_q.push_back(e);
      e = '0; e.mem_dst2 = 2'b11; e.mem_data = 3'b011; e.mem_write2 = 1'b1;
      e.pc_source = 1'b1; e.pc_write = 1'b1; exp_q.push_back(e);
    end else if (op == 4'd15) begin
      e = '0; e.mem_dst2 = 2'b11; e.mem_read2 = 1'b1; e.rs_pop = 1'b1; e.rs_pwrite = 1'b1;
      exp_q.push_back(e);
      e = '0; e.pc_source = 1'b1; e.pc_add = 1'b1; e.pc_write = 1'b1; exp_q.push_back(e);
    end
  endtask

  // Entered just after the edge that starts FETCH; returns just after the next FETCH edge
  task automatic run_instr(input logic [15:0] ir, input logic iz);
    ctrl_t e;
    int    step;
    IROut  = ir;
    isZero = iz;
    plan(ir[15:12], iz);
    step = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      check($sformatf("ctrl op=%h step=%0d", ir[15:12], step), 32'(act), 32'(e));
      step++;
      next_cycle();
    end
  endtask

  task automatic brz_seq(input logic iz);
    IROut  = 16'hD000;
    isZero = iz;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check($sformatf("brz iz=%0d PCWrite", iz), 32'(PCWrite), 32'(iz));
    check($sformatf("brz iz=%0d PCAdd", iz), 32'(PCAdd), 32'(iz));
    check($sformatf("brz iz=%0d MSPWrite", iz), 32'(MSPWrite), 32'd1);
    check($sformatf("brz iz=%0d MSPop", iz), 32'(MSPop), 32'd1);
    next_cycle();
    @(negedge CLK);
    check($sformatf("brz iz=%0d fetch after", iz), 32'(IRWrite), 32'd1);
    IROut = 16'h5000;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    dp_vec_t vecs[$];
    CtrlRst   = 1'b1;
    IROut     = 16'h0000;
    isZero    = 1'b0;
    ShifterIn = 16'h0000;

    vecs.push_back('{16'h8003, 16'hFFFA, 16'hFFD0, 16'h0003, 16'h0003});
    vecs.push_back('{16'h9004, 16'hFF9B, 16'h0FF9, 16'h0004, 16'h0004});
    vecs.push_back('{16'h9FFF, 16'hFF9B, 16'h0000, 16'h0FFF, 16'hFFFF});
    vecs.push_back('{16'hA004, 16'h8F00, 16'hF8F0, 16'h0004, 16'h0004});
    vecs.push_back('{16'hA010, 16'h8F00, 16'hFFFF, 16'h0010, 16'h0010});
    vecs.push_back('{16'hA00F, 16'h7FFF, 16'h0000, 16'h000F, 16'h000F});
    vecs.push_back('{16'h800F, 16'h0001, 16'h8000, 16'h000F, 16'h000F});
    vecs.push_back('{16'h8010, 16'hFFFF, 16'h0000, 16'h0010, 16'h0010});
    vecs.push_back('{16'h5123, 16'h1234, 16'h1234, 16'h0123, 16'h0123});
    vecs.push_back('{16'hB800, 16'hABCD, 16'hABCD, 16'h0800, 16'hF800});
    foreach (vecs[i]) begin
      IROut     = vecs[i].ir;
      ShifterIn = vecs[i].sin;
      #1;
      check($sformatf("vec%0d shift", i), 32'(ShifterOut), 32'(vecs[i].exp_shift));
      check($sformatf("vec%0d zext", i), 32'(ZeroExtOut), 32'(vecs[i].exp_zx));
      check($sformatf("vec%0d sext", i), 32'(SignExtOut), 32'(vecs[i].exp_sx));
    end

    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      case (n % 4)
        0: op = 4'b1000;
        1: op = 4'b1001;
        2: op = 4'b1010;
        default: begin
          op = 4'($urandom_range(0, 15));
          if (op >= 4'd8 && op <= 4'd10) op = 4'd12;
        end
      endcase
      IROut     = {op, 8'($urandom), 4'(n % 16)};
      IROut[11:4] = (n < 200) ? 8'h00 : 8'($urandom);
      ShifterIn = 16'hFFFF - 16'(n);
      next_cycle();
      check_dp($sformatf("sweep%0d", n));
    end

    // Reset forcing and release
    IROut = 16'hE000;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check("reset ctrl zero", 32'(act), 32'd0);
    next_cycle();
    CtrlRst = 1'b0;
    @(negedge CLK);
    check("post-reset IRWrite", 32'(IRWrite), 32'd1);
    check("post-reset PCWrite", 32'(PCWrite), 32'd1);
    check("post-reset MemRead1", 32'(MemRead1), 32'd1);
    next_cycle();
    @(negedge CLK);
    check("post-reset ValAWrite", 32'(ValAWrite), 32'd1);
    check("post-reset ValBWrite", 32'(ValBWrite), 32'd1);
    next_cycle();
    // CALL state now; reset mid-instruction abandons it
    CtrlRst = 1'b1;
    @(negedge CLK);
    check("mid-instr reset zero", 32'(act), 32'd0);
    next_cycle();
    CtrlRst = 1'b0;
    @(negedge CLK);
    check("mid-instr reset fetch", 32'(IRWrite), 32'd1);
    check("mid-instr reset no RSPWrite", 32'(RSPWrite), 32'd0);
    IROut = 16'h5000;
    next_cycle();
    next_cycle();

    brz_seq(1'b1);
    brz_seq(1'b0);

    for (int k = 0; k < 16; k++) run_instr({4'(k), 12'($urandom)}, 1'($urandom));
    for (int k = 0; k < 80; k++) begin
      ShifterIn = 16'($urandom);
      run_instr(16'($urandom), 1'($urandom));
      check_dp($sformatf("instr%0d dp", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage4_integration.md
Name: stage4_integration

Overview:
- Stage-4 integration block of the 16-bit stack-machine CPU.
- Combines four parts:
  - the multicycle control FSM (5-bit state), which drives every datapath control strobe;
  - the barrel shifter;
  - the 12→16 zero extender;
  - the 12→16 sign extender.
- The FSM and both extenders decode the instruction register output IROut. ShifterIn comes from the datapath and is shifted per IROut.

Parameters:
- none

Ports:
- CLK  in  1  system clock, rising edge
- CtrlRst  in  1  synchronous active-high reset of the control FSM
- IROut  in  16  instruction; [15:12] opcode, [11:0] immediate
- isZero  in  1  ALU zero flag
- ShifterIn  in  16  shifter operand
- ShifterOut  out  16  shift result
- ZeroExtOut  out  16  {4'h0, IROut[11:0]}
- SignExtOut  out  16  {4{IROut[11]}, IROut[11:0]}
- PCSource, PCWrite, PCAdd  out  1 each  PC source select / write enable / add-offset select
- MSPop, MSPWrite  out  1 each  main-stack pointer pop (1) or push (0) / write enable
- RSPop, RSPWrite  out  1 each  return-stack pointer pop or push / write enable
- IRWrite, ValAWrite, ValBWrite, ResWrite  out  1 each  register write enables
- ResSource  out  1  0 = ALU result, 1 = ShifterOut
- MemDst1, MemDst2  out  2 each  address select: 00 PC, 01 MS top, 10 MS top-1, 11 RS top
- MemData  out  3  write-data select: 000 Res, 001 ValB, 010 SignExt, 011 PC, 100 ZeroExt
- MemWrite1, MemWrite2, MemRead1, MemRead2  out  1 each  memory port strobes
- ALUop  out  3  ALU operation

Behaviour:
- One clock (CLK). Synchronous active-high reset (CtrlRst).

Datapath (purely combinational, independent of CLK and CtrlRst):
- Shift amount is the zero-extended IROut[11:0]. An amount ≥16 gives 0x0000 for logical shifts and 16 copies of ShifterIn[15] for arithmetic.
- Opcode 1000: ShifterOut = ShifterIn << amount.
- Opcode 1001: ShifterOut = ShifterIn >> amount (logical).
- Opcode 1010: ShifterOut = ShifterIn >>> amount (arithmetic).
- Any other opcode: ShifterOut = ShifterIn.
- ZeroExtOut and SignExtOut are valid for every opcode.

Control FSM:
- Moore machine. Outputs decode from the state only; any control signal not listed for a state is 0.
- On a CLK edge with CtrlRst = 1, state <= FETCH (0). While CtrlRst is high, all control outputs are forced to 0. Reset mid-instruction abandons that instruction.
- FETCH (0): MemDst1=00, MemRead1, IRWrite, PCWrite, PCSource=0, PCAdd=0 → DECODE.
- DECODE (1): MemDst1=01, MemRead1, ValAWrite; MemDst2=10, MemRead2, ValBWrite. Next state by opcode:
  - 0000–0100 → ALU
  - 1000–1010 → SHIFT
  - 1011 → PUSHI
  - 1100 → JUMP
  - 1101 → BRZ
  - 1110 → CALL
  - 1111 → RET
  - 0101–0111 (NOP) → FETCH
- ALU (2): ALUop = opcode[2:0], ResSource=0, ResWrite → WBPOP.
- WBPOP (3): MemDst1=10, MemData=000, MemWrite1, MSPop=1, MSPWrite → FETCH.
- SHIFT (4): ResSource=1, ResWrite → WBTOP.
- WBTOP (5): MemDst1=01, MemData=000, MemWrite1 → FETCH.
- PUSHI (6): MSPop=0, MSPWrite → PUSHW.
- PUSHW (7): MemDst1=01, MemData=010, MemWrite1 → FETCH.
- JUMP (8): PCSource=1, PCWrite → FETCH.
- BRZ (9): ALUop=001 (sub test); PCAdd=1 and PCWrite only when isZero=1; MSPop=1, MSPWrite → FETCH.
- CALL (10): RSPop=0, RSPWrite → CALLW.
- CALLW (11): MemDst2=11, MemData=011, MemWrite2, PCSource=1, PCWrite → FETCH.
- RET (12): MemDst2=11, MemRead2, RSPop=1, RSPWrite → RETW.
- RETW (13): PCSource=1, PCAdd=1, PCWrite → FETCH.
- State codes 14–31 are illegal and go to FETCH on the next edge.

Test Plan:
- IROut=0x8003, ShifterIn=0xFFFA → ShifterOut=0xFFD0, ZeroExtOut=0x0003, SignExtOut=0x0003.
- IROut=0x9004, ShifterIn=0xFF9B → ShifterOut=0x0FF9; IROut=0x9FFF → ShifterOut=0x0000, SignExtOut=0xFFFF.
- IROut=0xA004, ShifterIn=0x8F00 → ShifterOut=0xF8F0; IROut=0xA010 → ShifterOut=0xFFFF.
- Sweep opcodes 1000/1001/1010 with amount 0–15 and ShifterIn = 0xFFFF − n over 300 cycles → zero mismatches against the shift/extension reference.
- CtrlRst=1 for 2 cycles → all control outputs 0. Release → FETCH: IRWrite=1, PCWrite=1, MemRead1=1. Next cycle DECODE: ValAWrite=1, ValBWrite=1.
- BRZ (IROut=0xD000):
  - isZero=1 in BRZ → PCWrite=1, PCAdd=1.
  - isZero=0 → PCWrite=0, MSPWrite=1.
  - Either way FETCH follows.
